// File: rtl/seq_tx.sv
// seq_tx: repeating serial pattern transmitter.
// Captures a pattern, its length and a repeat count, then shifts the used
// field out MSB-first, once per frame. Frames are separated by GAP_CYCLES
// idle cycles, and a one-cycle done pulse follows the last frame.
// Every output is registered and changes only on the rising edge of clk.
module seq_tx #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DATA_W-1:0]         pattern,
  input  logic [$clog2(DATA_W):0]   len,
  input  logic [3:0]                reps,
  input  logic                      abort,
  output logic                      dout,
  output logic                      dout_valid,
  output logic                      busy,
  output logic                      done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] pat_q;
  logic [IDX_W-1:0]  last_idx_q;
  logic [IDX_W-1:0]  idx_q;
  logic [3:0]        frames_q;
  logic [GAP_W-1:0]  gap_q;

  logic [IDX_W-1:0]  in_last_idx;
  logic [IDX_W-1:0]  next_idx;

  // First bit index of a new frame; a length of 0 or beyond DATA_W means the full width.
  always_comb begin
    in_last_idx = IDX_W'(DATA_W - 1);
    if ((len != '0) && (int'(len) <= DATA_W)) begin
      in_last_idx = IDX_W'(len - 1'b1);
    end
    next_idx = idx_q - IDX_W'(1);
  end

  // Transfer FSM with registered outputs; reset beats abort, and abort beats start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pat_q      <= '0;
      last_idx_q <= '0;
      idx_q      <= '0;
      frames_q   <= '0;
      gap_q      <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dout       <= 1'b0;
          dout_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          if (start && !abort) begin
            pat_q      <= pattern;
            last_idx_q <= in_last_idx;
            idx_q      <= in_last_idx;
            frames_q   <= reps;
            dout       <= pattern[in_last_idx];
            dout_valid <= 1'b1;
            busy       <= 1'b1;
            state      <= SHIFT;
          end
        end

        SHIFT: begin
          if (abort) begin
            state      <= IDLE;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
          end else if (idx_q != '0) begin
            idx_q <= next_idx;
            dout  <= pat_q[next_idx];
          end else if (frames_q != 4'd0) begin
            frames_q <= frames_q - 4'd1;
            if (GAP_CYCLES > 0) begin
              state      <= GAP;
              gap_q      <= GAP_W'(GAP_CYCLES - 1);
              dout       <= 1'b0;
              dout_valid <= 1'b0;
            end else begin
              idx_q <= last_idx_q;
              dout  <= pat_q[last_idx_q];
            end
          end else begin
            state      <= DONE;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
        end

        GAP: begin
          if (abort) begin
            state      <= IDLE;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
          end else if (gap_q == '0) begin
            state      <= SHIFT;
            idx_q      <= last_idx_q;
            dout       <= pat_q[last_idx_q];
            dout_valid <= 1'b1;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end

        DONE: begin
          state      <= IDLE;
          dout       <= 1'b0;
          dout_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end

        default: begin
          state      <= IDLE;
          dout       <= 1'b0;
          dout_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_tx.sv
// tb_seq_tx: drives two seq_tx instances (GAP_CYCLES=2 and GAP_CYCLES=0)
// with the same inputs. The reference expands each accepted request into the
// list of per-cycle output tuples {dout, dout_valid, busy, done} it must
// produce, and a negedge process compares both DUTs against that list.
module tb_seq_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] reps;

  logic dout2, valid2, busy2, done2;
  logic dout0, valid0, busy0, done0;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  logic [3:0] q2[$];
  logic [3:0] q0[$];
  bit         idle2 = 1'b1;
  bit         idle0 = 1'b1;
  logic [3:0] e2;
  logic [3:0] e0;

  logic [3:0] hist2[0:8191];
  logic [3:0] hist0[0:8191];

  always #5 clk = ~clk;

  seq_tx #(.DATA_W(8), .GAP_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
    .reps(reps), .abort(abort), .dout(dout2), .dout_valid(valid2),
    .busy(busy2), .done(done2)
  );

  seq_tx #(.DATA_W(8), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
    .reps(reps), .abort(abort), .dout(dout0), .dout_valid(valid0),
    .busy(busy0), .done(done0)
  );

  // Count one comparison and report it when the values differ.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Expand one accepted request into the exact cycle-by-cycle output list.
  task automatic buildTransfer(input bit gap0, input logic [7:0] pat, input logic [3:0] ln, input logic [3:0] rp);
    int n;
    int gap;
    n   = ((ln == 4'd0) || (ln > 4'd8)) ? 8 : int'(ln);
    gap = gap0 ? 0 : 2;
    for (int f = 0; f <= int'(rp); f++) begin
      for (int i = n - 1; i >= 0; i--) begin
        if (gap0) q0.push_back({pat[i], 3'b110});
        else      q2.push_back({pat[i], 3'b110});
      end
      if (f < int'(rp)) begin
        for (int g = 0; g < gap; g++) begin
          if (gap0) q0.push_back(4'b0010);
          else      q2.push_back(4'b0010);
        end
      end
    end
    if (gap0) q0.push_back(4'b0001);
    else      q2.push_back(4'b0001);
  endtask

  // Concatenate one output field over a range of logged cycles, earliest cycle first.
  function automatic logic [31:0] packField(input bit gap0, input int a, input int b, input int pos);
    logic [31:0] r;
    logic [3:0]  e;
    r = '0;
    for (int c = a; c <= b; c++) begin
      e = gap0 ? hist0[c] : hist2[c];
      r = {r[30:0], e[pos]};
    end
    return r;
  endfunction

  // Compare process: log outputs and check both DUTs against the reference every cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (cyc < 8192) begin
      hist2[cyc] = {dout2, valid2, busy2, done2};
      hist0[cyc] = {dout0, valid0, busy0, done0};
    end
    if (chk_en) begin
      if (q2.size() > 0) begin e2 = q2.pop_front(); idle2 = 1'b0; end
      else begin e2 = 4'b0000; idle2 = 1'b1; end
      if (q0.size() > 0) begin e0 = q0.pop_front(); idle0 = 1'b0; end
      else begin e0 = 4'b0000; idle0 = 1'b1; end
      checkOutput($sformatf("cycle%0d_gap2", cyc), 32'({dout2, valid2, busy2, done2}), 32'(e2));
      checkOutput($sformatf("cycle%0d_gap0", cyc), 32'({dout0, valid0, busy0, done0}), 32'(e0));
    end
  end

  // Drive one cycle of inputs and advance the reference by the same rules.
  task automatic applyStimulus(input bit st, input logic [7:0] pat, input logic [3:0] ln,
                               input logic [3:0] rp, input bit ab, input bit rs);
    @(negedge clk);
    #1;
    start   = st;
    pattern = pat;
    len     = ln;
    reps    = rp;
    abort   = ab;
    reset   = rs;
    if (rs) begin
      q2.delete();
      q0.delete();
    end else if (ab) begin
      if (!idle2) q2.delete();
      if (!idle0) q0.delete();
    end else if (st) begin
      if (idle2) buildTransfer(1'b0, pat, ln, rp);
      if (idle0) buildTransfer(1'b1, pat, ln, rp);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  int s;

  // Directed scenarios first, then randomized traffic.
  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    pattern = 8'h00; len = 4'd0; reps = 4'd0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    applyStimulus(1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0);
    checkOutput("reset_state_gap2", 32'(hist2[cyc]), 32'h0);
    checkOutput("reset_state_gap0", 32'(hist0[cyc]), 32'h0);
    idleCycles(2);

    // single frame
    applyStimulus(1'b1, 8'h0B, 4'd4, 4'd0, 1'b0, 1'b0);
    s = cyc;
    idleCycles(7);
    checkOutput("single_dout",  packField(1'b0, s + 1, s + 4, 3), 32'b1011);
    checkOutput("single_valid", packField(1'b0, s + 1, s + 4, 2), 32'hF);
    checkOutput("single_done",  32'(hist2[s + 5]), 32'b0001);
    checkOutput("single_idle",  32'(hist2[s + 6]), 32'h0);

    // two frames separated by a gap
    applyStimulus(1'b1, 8'hA5, 4'd8, 4'd1, 1'b0, 1'b0);
    s = cyc;
    idleCycles(21);
    checkOutput("gap_frame1",  packField(1'b0, s + 1, s + 8, 3), 32'hA5);
    checkOutput("gap_valid1",  packField(1'b0, s + 1, s + 8, 2), 32'hFF);
    checkOutput("gap_cycle9",  32'(hist2[s + 9]), 32'b0010);
    checkOutput("gap_cycle10", 32'(hist2[s + 10]), 32'b0010);
    checkOutput("gap_frame2",  packField(1'b0, s + 11, s + 18, 3), 32'hA5);
    checkOutput("gap_done",    32'(hist2[s + 19]), 32'b0001);

    // back-to-back frames
    applyStimulus(1'b1, 8'h02, 4'd2, 4'd2, 1'b0, 1'b0);
    s = cyc;
    idleCycles(12);
    checkOutput("b2b_dout",  packField(1'b1, s + 1, s + 6, 3), 32'b101010);
    checkOutput("b2b_valid", packField(1'b1, s + 1, s + 6, 2), 32'h3F);
    checkOutput("b2b_done",  32'(hist0[s + 7]), 32'b0001);

    // abort mid-frame, then a fresh start is accepted
    applyStimulus(1'b1, 8'h5C, 4'd8, 4'd0, 1'b0, 1'b0);
    s = cyc;
    idleCycles(2);
    applyStimulus(1'b0, 8'h00, 4'd0, 4'd0, 1'b1, 1'b0);
    idleCycles(1);
    applyStimulus(1'b1, 8'hC3, 4'd8, 4'd0, 1'b0, 1'b0);
    idleCycles(12);
    checkOutput("abort_outputs", 32'(hist2[s + 4]), 32'h0);
    checkOutput("abort_no_done", packField(1'b0, s + 1, s + 5, 0), 32'h0);
    checkOutput("abort_restart", 32'(hist2[s + 6]), 32'b1110);

    // length clamp; start ignored in SHIFT and in DONE
    applyStimulus(1'b1, 8'hFF, 4'd0, 4'd0, 1'b0, 1'b0);
    s = cyc;
    idleCycles(2);
    applyStimulus(1'b1, 8'h00, 4'd4, 4'd3, 1'b0, 1'b0);
    idleCycles(5);
    applyStimulus(1'b1, 8'hF0, 4'd4, 4'd0, 1'b0, 1'b0);
    idleCycles(4);
    checkOutput("clamp_valid", packField(1'b0, s + 1, s + 8, 2), 32'hFF);
    checkOutput("clamp_dout",  packField(1'b0, s + 1, s + 8, 3), 32'hFF);
    checkOutput("clamp_done",  32'(hist2[s + 9]), 32'b0001);
    checkOutput("ignore_start_after_done", 32'(hist2[s + 10]), 32'h0);
    checkOutput("ignore_start_idle", 32'(hist2[s + 11]), 32'h0);

    // reset in mid-transfer
    applyStimulus(1'b1, 8'h96, 4'd8, 4'd0, 1'b0, 1'b0);
    s = cyc;
    idleCycles(2);
    applyStimulus(1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 1'b1);
    idleCycles(9);
    checkOutput("reset_mid_outputs", 32'(hist2[s + 4]), 32'h0);
    checkOutput("reset_mid_no_done", packField(1'b0, s + 1, s + 12, 0), 32'h0);

    // maximum repeat count: 16 frames
    applyStimulus(1'b1, 8'h01, 4'd1, 4'd15, 1'b0, 1'b0);
    s = cyc;
    idleCycles(50);
    checkOutput("reps15_valid_gap0", packField(1'b1, s + 1, s + 16, 2), 32'hFFFF);
    checkOutput("reps15_done_gap0",  32'(hist0[s + 17]), 32'b0001);
    checkOutput("reps15_done_gap2",  32'(hist2[s + 47]), 32'b0001);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0),
                    8'($urandom),
                    4'($urandom_range(0, 15)),
                    ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 2)),
                    ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 149) == 0));
    end
    idleCycles(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_tx.md
SEQ_TX -- requirements
Module: seq_tx

Interface
REQ-001 Parameter DATA_W, default 8: maximum pattern length in bits.
REQ-002 Parameter GAP_CYCLES, default 2: idle cycles inserted between repeated frames; 0 is legal.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to transmit; sampled only in IDLE.
REQ-006 pattern  input  DATA_W  bits to send; bit len-1 goes first (MSB-first of the used field).
REQ-007 len  input  $clog2(DATA_W)+1  number of bits per frame.
REQ-008 reps  input  4  extra repetitions; frames sent = reps+1.
REQ-009 abort  input  1  terminate the transfer in progress.
REQ-010 dout  output  1  serial data bit, registered.
REQ-011 dout_valid  output  1  dout carries a pattern bit this cycle, registered.
REQ-012 busy  output  1  a transfer is in progress, registered.
REQ-013 done  output  1  one-cycle pulse after the last bit of the last frame, registered.

Function
REQ-014 The FSM SHALL have the states IDLE, SHIFT, GAP and DONE.
REQ-015 In IDLE, start=1 with abort=0 SHALL capture pattern, len and reps into internal registers and enter SHIFT on the next edge.
REQ-016 Input changes after capture SHALL have no effect on the transfer in progress.
REQ-017 A len of 0 or greater than DATA_W SHALL be treated as DATA_W.
REQ-018 In SHIFT, the block SHALL drive dout_valid=1 and dout=captured pattern bit index, with index starting at len-1 and decrementing by 1 per cycle down to 0.
REQ-019 After bit 0, with frames remaining and GAP_CYCLES>0, the FSM SHALL enter GAP for exactly GAP_CYCLES cycles, then return to SHIFT at index len-1.
REQ-020 After bit 0, with frames remaining and GAP_CYCLES=0, the FSM SHALL restart SHIFT at index len-1 on the next cycle, giving back-to-back frames.
REQ-021 After bit 0 of the last frame, the FSM SHALL enter DONE for one cycle, assert done=1 in that cycle, then return to IDLE.
REQ-022 In GAP, DONE and IDLE, the block SHALL drive dout=0 and dout_valid=0.
REQ-023 busy SHALL be 1 in SHIFT and GAP and 0 in IDLE and DONE.
REQ-024 start SHALL be ignored in every state other than IDLE, including DONE.
REQ-025 abort=1 in SHIFT, GAP or DONE SHALL force IDLE on the next edge, with dout_valid=0, busy=0 and no done pulse.
REQ-026 abort=1 and start=1 together in IDLE SHALL leave the FSM in IDLE; abort wins.
REQ-027 The frame counter SHALL count from reps down to 0 without wrap-around; reps=15 SHALL send exactly 16 frames.
REQ-028 The bit-index counter SHALL never underflow; the transition at index 0 follows REQ-019 to REQ-021.

Reset
REQ-029 reset=1 SHALL, on the next edge, set state=IDLE, dout=0, dout_valid=0, busy=0 and done=0, and clear all counters and captured registers.
REQ-030 reset SHALL take priority over start and abort.
REQ-031 reset asserted in mid-transfer SHALL abandon the transfer with no done pulse.

Verification
REQ-032 Single frame: pattern=8'h0B, len=4, reps=0, start pulse at cycle 0 -> cycles 1-4 dout=1,0,1,1 with dout_valid=1 -> cycle 5 done=1 -> cycle 6 IDLE.
REQ-033 Repeat with gap: pattern=8'hA5, len=8, reps=1, GAP_CYCLES=2 -> cycles 1-8 dout=10100101 -> cycles 9-10 dout_valid=0 -> cycles 11-18 dout=10100101 -> cycle 19 done=1.
REQ-034 Back-to-back frames: GAP_CYCLES=0, pattern=8'h02, len=2, reps=2 -> cycles 1-6 dout=1,0,1,0,1,0 with dout_valid=1 throughout -> cycle 7 done=1.
REQ-035 Abort: start at cycle 0 with len=8, abort at cycle 3 -> cycle 4 dout_valid=0, busy=0; done stays 0; a new start at cycle 5 is accepted.
REQ-036 Length clamp and ignored start: len=0, pattern=8'hFF -> 8 bits sent; a start pulse during SHIFT and in the DONE cycle produces no second transfer.
REQ-037 Reset mid-transfer: reset=1 at cycle 3 of an 8-bit frame -> next edge all outputs 0, state IDLE, no done pulse.
